// File: rtl/pipe_gate_pkg.sv
// pipe_gate_pkg: combine-function encoding, parameter limits and the bitwise gate for pipe_gate_reg.
package pipe_gate_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } mode_t;

    localparam int B_PRE_MAX = 4;
    localparam int DEPTH_MAX = 8;

    function automatic logic gate_f(input mode_t mode, input logic a, input logic b);
        return mode == MODE_AND ? a & b :
               mode == MODE_OR  ? a | b :
               mode == MODE_XOR ? a ^ b : ~(a & b);
    endfunction

endpackage

// File: rtl/pipe_gate_stage.sv
// pipe_gate_stage: one data register plus valid bit; flush clears only the valid bit.
module pipe_gate_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (en) q <= d;
            q_valid <= flush ? 1'b0 : en ? d_valid : q_valid;
        end
    end

endmodule

// File: rtl/pipe_gate_reg.sv
// pipe_gate_reg: b delayed by B_PRE stages, gated bitwise with a, then DEPTH output stages
// with valid tracking, global hold and synchronous flush.
module pipe_gate_reg
    import pipe_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int B_PRE = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             hold,
    input  logic             flush,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    if (B_PRE < 0 || B_PRE > B_PRE_MAX || DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_param
        $fatal(1, "pipe_gate_reg: B_PRE must be 0..4 and DEPTH 1..8");
    end

    logic [WIDTH-1:0] b_del;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] dq [DEPTH];
    logic [DEPTH-1:0] vq;

    if (B_PRE == 0) begin : g_b_direct
        assign b_del = b;
    end else begin : g_b_pipe
        logic [WIDTH-1:0] bs [B_PRE];
        // The b path ignores flush: only valid bits are cleared, data keeps flowing.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < B_PRE; i++) bs[i] <= '0;
            end else if (!hold) begin
                bs[0] <= b;
                for (int i = 1; i < B_PRE; i++) bs[i] <= bs[i-1];
            end
        end
        assign b_del = bs[B_PRE-1];
    end

    always_comb begin
        f = '0;
        for (int i = 0; i < WIDTH; i++) f[i] = gate_f(mode_t'(mode), a[i], b_del[i]);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_gate_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (!hold),
            .flush   (flush),
            .d       (g == 0 ? f : dq[g == 0 ? 0 : g-1]),
            .d_valid (g == 0 ? in_valid : vq[g == 0 ? 0 : g-1]),
            .q       (dq[g]),
            .q_valid (vq[g])
        );
    end

    assign out       = dq[DEPTH-1];
    assign out_valid = vq[DEPTH-1];
    assign busy      = |vq;

endmodule

// File: doc/pipe_gate_reg.md
Name: pipe_gate_reg

Overview:
- Parametrised registered two-operand gate pipeline, for use in timing-characterisation and datapath test structures.
- Operand b passes through B_PRE register stages. It is then combined with unregistered operand a by a selectable bitwise function.
- The result passes through DEPTH output register stages.
- Adds multi-bit width, selectable function, valid tracking, a global hold (stall) and a synchronous flush.

Parameters:
- WIDTH, 1, data width of a, b and out.
- B_PRE, 1, register stages on the b path before the combine point; 0 to 4 legal.
- DEPTH, 2, register stages after the combine point; 1 to 8 legal.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous active-low reset; all state clears while low.
- a  input  WIDTH  operand a, qualified by in_valid.
- b  input  WIDTH  operand b, free-running stream.
- in_valid  input  1  a is valid this cycle.
- hold  input  1  stall: all registers keep their value.
- flush  input  1  synchronous clear of all valid bits.
- mode  input  2  combine function: 00 AND, 01 OR, 10 XOR, 11 NAND.
- out  output  WIDTH  last output-stage data register.
- out_valid  output  1  last output-stage valid bit.
- busy  output  1  OR of all output-stage valid bits.

Behaviour:
- Reset (reset low, asynchronous): every b-stage, data-stage and valid register goes to 0. Therefore out=0, out_valid=0, busy=0. Release is synchronous to clk.
- Advance: on each rising edge with hold=0, every stage shifts by one.
  - b stage 0 captures b.
  - Output stage 0 captures f(a, b_del) and in_valid.
  - b_del is the last b-stage, or b itself when B_PRE=0.
- f is evaluated bitwise on the current mode. mode is not registered; a mode change affects only the beat entering output stage 0 that cycle.
- Latency:
  - a to out: exactly DEPTH advancing edges.
  - b to out: B_PRE+DEPTH advancing edges.
  - in_valid to out_valid: DEPTH advancing edges.
- Hold: with hold=1 and flush=0, all registers (b path, data, valid) keep their value. Outputs are static.
- Flush: with flush=1, all valid bits clear to 0 on the edge, regardless of hold.
  - Data and b-path registers behave as if flush were 0: they advance when hold=0 and keep their value when hold=1.
  - in_valid on a flush cycle is discarded.
- Priority: reset > flush > hold > advance.
- out data is always driven, including when out_valid=0. Consumers qualify it with out_valid.
- busy=1 while any output-stage valid bit is 1. busy is registered-derived, with no combinational path from inputs.
- No combinational path from any input to any output.
- Legacy equivalence: WIDTH=1, B_PRE=1, DEPTH=2, mode=00, hold=0, flush=0 gives out(t) = a(t-2) & b(t-3).
- Out-of-range parameters stop elaboration with a fatal error.

Decomposition:
- Package pipe_gate_pkg:
  - 2-bit mode type with constants MODE_AND, MODE_OR, MODE_XOR, MODE_NAND.
  - B_PRE_MAX=4 and DEPTH_MAX=8.
  - Function gate_f(mode, a, b) returning the combine result.
- Sub-module pipe_gate_stage: one WIDTH-bit data register plus valid bit, with enable (!hold), flush and async active-low reset. It is instantiated DEPTH times.
- The b-path stages are plain enabled registers in the top module.

Test Plan (WIDTH=8, B_PRE=1, DEPTH=2 unless stated):
- Reset mid-stream: drive valid beats, pull reset low between edges -> out=0x00, out_valid=0 and busy=0 immediately, with no clock edge needed.
- Latency and AND: b=0xF0 at cycle 0, then a=0x3C with in_valid=1 at cycle 1, mode=00 -> out=0x30 and out_valid=1 after the 3rd edge, out_valid=0 after the 4th.
- Modes: b held at 0xAA and a held at 0x0F, stepping mode 00/01/10/11 one cycle each -> out sequence 0x0A, 0xAF, 0xA5, 0xF5, each two edges after its mode.
- Hold: stream a=1,2,3,4 with b=0xFF; assert hold for 3 cycles mid-stream -> out sequence 1,2,3,4 unchanged and no beat lost or duplicated; out frozen during hold.
- Flush with hold: 2 beats in flight, flush=1 and hold=1 together -> out_valid=0 and busy=0 next edge; a new beat then appears exactly DEPTH edges after its injection.
- Parameter sweep: B_PRE=0, DEPTH=1 -> out = a op b one edge later; B_PRE=4, DEPTH=8 -> b-to-out latency is 12 edges.
